ras_shadow_stack_ctrl: RTL and testbench
========================================

# ras_shadow_stack_ctrl

Commit-side controller for the return-address shadow stack. It watches committed call/return events, pushes the computed return address on calls, and on returns pops and compares the stack top against the actual return target. Mismatches and underflows raise a registered violation and a sticky fault. Calls beyond the stack depth are tracked with a spill counter. It sits between the commit stage and the shadow stack and drives that stack's push/pop/data inputs.

## Interface
Parameters:
- XLEN, 64, address width; equals the shadow stack DATA_W.
- SPILL_W, 8, width of the spill counter.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- i_enable  in  1  checking enable.
- i_clear  in  1  one-cycle pulse; leaves FAULT.
- i_valid  in  1  commit event valid.
- o_ready  out  1  event accepted when i_valid & o_ready.
- i_is_call  in  1  event is a call (link to ra/t0).
- i_is_ret  in  1  event is a return.
- i_pc  in  XLEN  PC of the committed instruction.
- i_compressed  in  1  instruction is 16-bit.
- i_target  in  XLEN  actual return target.
- o_ss_push  out  1  push to the shadow stack.
- o_ss_data  out  XLEN  push data.
- o_ss_pop  out  1  pop from the shadow stack.
- i_ss_top  in  XLEN  current stack top, zero-latency.
- i_ss_full  in  1  stack full.
- i_ss_empty  in  1  stack empty.
- o_violation  out  1  registered one-cycle pulse.
- o_fault  out  1  sticky; high in FAULT.
- o_fault_pc  out  XLEN  i_pc of the violating event.
- o_spill_cnt  out  SPILL_W  calls not stored because the stack was full.
- o_calls  out  CNT_W  accepted-call count.
- o_rets  out  CNT_W  accepted-return count.

## Operation
- States: DISABLED, RUN, PUSH_PEND, FAULT. Reset state is DISABLED.
- DISABLED:
  - o_ready=1; events are dropped; no stack traffic.
  - i_enable=1 moves to RUN.
- In any non-FAULT state, i_enable=0 moves to DISABLED. The spill counter is retained.
- Return address: ra = i_pc + (i_compressed ? 2 : 4), modulo 2^XLEN.
- RUN, accepted call only:
  - If !i_ss_full: o_ss_push=1, o_ss_data=ra.
  - If i_ss_full: spill counter increments and nothing is pushed.
  - If the spill counter is already at its maximum: violation.
- RUN, accepted ret only:
  - Spill counter > 0: decrement it; no pop, no check.
  - Else if i_ss_empty: violation (underflow).
  - Else: o_ss_pop=1. If i_target != i_ss_top: violation.
- RUN, accepted event with both call and ret (coroutine swap):
  - Do the ret handling this cycle and latch ra.
  - Go to PUSH_PEND. o_ss_push and o_ss_pop are never asserted together.
- PUSH_PEND:
  - o_ready=0.
  - Perform the latched call handling (push or spill).
  - Return to RUN next cycle.
- Violation:
  - o_violation pulses the following cycle.
  - o_fault_pc is captured.
  - State goes to FAULT.
- FAULT:
  - o_ready=1; events are dropped; no stack traffic.
  - i_clear returns to RUN.
  - Stack contents and spill counter are untouched; software resets the stack if needed.
- Events with i_valid & !i_is_call & !i_is_ret are accepted and ignored.

## Timing
- All outputs reset asynchronously to 0, except o_ready, which is 1 (DISABLED accepts).
- o_ss_push, o_ss_pop and o_ss_data are combinational from the accepted event and the current state, in the same cycle.
- The comparison uses same-cycle i_ss_top.
- Violation latency: o_violation, o_fault and o_fault_pc are valid one cycle after acceptance.
- A coroutine event costs 2 cycles; o_ready is low for exactly one cycle.
- Reset asserted mid-PUSH_PEND drops the pending push.
- i_clear and a new event in the same cycle: the state becomes RUN, and the event is dropped.
- o_calls and o_rets wrap modulo 2^CNT_W.

## Configuration
- SS_CTRL_STATS_EN defined: o_calls and o_rets count accepted call/return events in RUN and PUSH_PEND.
- SS_CTRL_STATS_EN undefined: the counters are not built, and o_calls and o_rets are tied to 0.

## Test plan
- Enable, then call at pc=0x1000 (not compressed), then ret with target 0x1004 -> push 0x1004; pop; no violation.
- Enable, then call at pc=0x2000 with i_compressed=1, then ret with target 0x2004 -> push 0x2002; o_violation is high one cycle after the ret; o_fault_pc=the ret PC; state FAULT; o_ready=1.
- Ret with the stack empty and spill=0 -> underflow violation. Then i_clear -> RUN; the next call pushes normally.
- With i_ss_full=1, three calls -> spill=3, no pushes. Three rets -> spill returns to 0; no pops, no violation.
- Coroutine event (call+ret, ra=0x3004, top equals target) -> pop in cycle N; o_ready=0 and push 0x3004 in cycle N+1.
- Reset asserted during PUSH_PEND -> no push; o_ready=1; all other outputs 0.

Source files
------------

// File: rtl/ras_shadow_stack_ctrl.sv
// Commit-side return-address shadow stack controller: pushes return addresses on calls, checks pops on returns.
// Optional build macro SS_CTRL_STATS_EN adds accepted call/return statistics counters.
module ras_shadow_stack_ctrl #(
    parameter int XLEN    = 64,
    parameter int SPILL_W = 8,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_enable,
    input  logic               i_clear,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_is_call,
    input  logic               i_is_ret,
    input  logic [XLEN-1:0]    i_pc,
    input  logic               i_compressed,
    input  logic [XLEN-1:0]    i_target,
    output logic               o_ss_push,
    output logic [XLEN-1:0]    o_ss_data,
    output logic               o_ss_pop,
    input  logic [XLEN-1:0]    i_ss_top,
    input  logic               i_ss_full,
    input  logic               i_ss_empty,
    output logic               o_violation,
    output logic               o_fault,
    output logic [XLEN-1:0]    o_fault_pc,
    output logic [SPILL_W-1:0] o_spill_cnt,
    output logic [CNT_W-1:0]   o_calls,
    output logic [CNT_W-1:0]   o_rets
);

    typedef enum logic [1:0] {DISABLED, RUN, PUSH_PEND, FAULT} state_t;

    state_t             state;
    logic [SPILL_W-1:0] spill_q;
    logic [XLEN-1:0]    pend_ra_p1;
    logic [XLEN-1:0]    pend_pc_p1;

    function automatic logic [XLEN-1:0] ret_addr(input logic [XLEN-1:0] pc, input logic comp);
        return pc + (comp ? XLEN'(2) : XLEN'(4));
    endfunction

    logic            run_ev, ret_go, coro, pend_go, do_call;
    logic            spill_max, spill_nz, spill_inc, spill_dec;
    logic            call_viol, ret_viol, viol;
    logic [XLEN-1:0] call_ra, viol_pc;

    // Event decode: disabling takes priority over any event or pending push.
    assign run_ev    = (state == RUN) && i_enable && i_valid && o_ready;
    assign ret_go    = run_ev && i_is_ret;
    assign coro      = run_ev && i_is_call && i_is_ret;
    assign pend_go   = (state == PUSH_PEND) && i_enable;
    assign do_call   = (run_ev && i_is_call && !i_is_ret) || pend_go;
    assign call_ra   = pend_go ? pend_ra_p1 : ret_addr(i_pc, i_compressed);

    assign spill_max = &spill_q;
    assign spill_nz  = |spill_q;
    assign spill_inc = do_call && i_ss_full && !spill_max;
    assign spill_dec = ret_go && spill_nz;
    assign call_viol = do_call && i_ss_full && spill_max;
    assign ret_viol  = ret_go && !spill_nz && (i_ss_empty || (i_target != i_ss_top));
    assign viol      = call_viol || ret_viol;
    assign viol_pc   = pend_go ? pend_pc_p1 : i_pc;

    assign o_ss_push   = do_call && !i_ss_full;
    assign o_ss_pop    = ret_go && !spill_nz && !i_ss_empty;
    assign o_ss_data   = o_ss_push ? call_ra : '0;
    assign o_spill_cnt = spill_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= DISABLED;
            o_ready     <= 1'b1;
            o_fault     <= 1'b0;
            o_violation <= 1'b0;
            o_fault_pc  <= '0;
            spill_q     <= '0;
        end else begin
            o_violation <= viol;
            if (viol) o_fault_pc <= viol_pc;
            if (spill_inc)      spill_q <= spill_q + SPILL_W'(1);
            else if (spill_dec) spill_q <= spill_q - SPILL_W'(1);
            case (state)
                DISABLED: begin
                    if (i_enable) state <= RUN;
                end
                RUN, PUSH_PEND: begin
                    // A violating return wins over a coroutine's deferred push.
                    if (!i_enable) begin
                        state   <= DISABLED;
                        o_ready <= 1'b1;
                    end else if (viol) begin
                        state   <= FAULT;
                        o_ready <= 1'b1;
                        o_fault <= 1'b1;
                    end else if (coro) begin
                        state   <= PUSH_PEND;
                        o_ready <= 1'b0;
                    end else begin
                        state   <= RUN;
                        o_ready <= 1'b1;
                    end
                end
                FAULT: begin
                    if (i_clear) begin
                        state   <= RUN;
                        o_fault <= 1'b0;
                    end
                end
                default: begin
                    state   <= DISABLED;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

    // Deferred call half of a coroutine swap.
    always_ff @(posedge clk) begin
        if (coro) begin
            pend_ra_p1 <= ret_addr(i_pc, i_compressed);
            pend_pc_p1 <= i_pc;
        end
    end

`ifdef SS_CTRL_STATS_EN
    logic [CNT_W-1:0] calls_q, rets_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            calls_q <= '0;
            rets_q  <= '0;
        end else begin
            calls_q <= calls_q + CNT_W'(run_ev && i_is_call);
            rets_q  <= rets_q + CNT_W'(run_ev && i_is_ret);
        end
    end

    assign o_calls = calls_q;
    assign o_rets  = rets_q;
`else
    assign o_calls = '0;
    assign o_rets  = '0;
`endif

endmodule

// File: tb/tb_ras_shadow_stack_ctrl.sv
// Scoreboard bench for ras_shadow_stack_ctrl: directed events, expected stack traffic and violations queued and
// checked by an independent monitor.
module tb_ras_shadow_stack_ctrl;

    localparam int XLEN = 64, SPILL_W = 8, CNT_W = 32;
    localparam logic [1:0] K_PUSH = 2'd0, K_POP = 2'd1, K_VIOL = 2'd2;

    logic clk = 1'b0, rstn;
    logic i_enable, i_clear, i_valid, o_ready, i_is_call, i_is_ret, i_compressed;
    logic [XLEN-1:0] i_pc, i_target, o_ss_data, i_ss_top, o_fault_pc;
    logic o_ss_push, o_ss_pop, i_ss_full, i_ss_empty, o_violation, o_fault;
    logic [SPILL_W-1:0] o_spill_cnt;
    logic [CNT_W-1:0] o_calls, o_rets;

    ras_shadow_stack_ctrl #(.XLEN(XLEN), .SPILL_W(SPILL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .i_enable(i_enable), .i_clear(i_clear), .i_valid(i_valid),
        .o_ready(o_ready), .i_is_call(i_is_call), .i_is_ret(i_is_ret), .i_pc(i_pc),
        .i_compressed(i_compressed), .i_target(i_target), .o_ss_push(o_ss_push),
        .o_ss_data(o_ss_data), .o_ss_pop(o_ss_pop), .i_ss_top(i_ss_top), .i_ss_full(i_ss_full),
        .i_ss_empty(i_ss_empty), .o_violation(o_violation), .o_fault(o_fault),
        .o_fault_pc(o_fault_pc), .o_spill_cnt(o_spill_cnt), .o_calls(o_calls), .o_rets(o_rets)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      kind;
        logic [XLEN-1:0] data;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [XLEN-1:0] data);
        sb_q.push_back('{kind: kind, data: data});
    endtask

    task automatic observe(input logic [1:0] kind, input logic [XLEN-1:0] data);
        sb_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got kind %0d data 0x%0h expected nothing at %0t", kind, data, $time);
        end else begin
            e = sb_q.pop_front();
            chk("sb_kind", 64'(kind), 64'(e.kind));
            if (kind != K_POP) chk("sb_data", 64'(data), 64'(e.data));
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                if (o_ss_push)   observe(K_PUSH, o_ss_data);
                if (o_ss_pop)    observe(K_POP, '0);
                if (o_violation) observe(K_VIOL, o_fault_pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic call, input logic ret, input logic [XLEN-1:0] pc,
                      input logic comp, input logic [XLEN-1:0] tgt);
        i_valid = 1'b1; i_is_call = call; i_is_ret = ret;
        i_pc = pc; i_compressed = comp; i_target = tgt;
        step();
        i_valid = 1'b0; i_is_call = 1'b0; i_is_ret = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; i_enable = 1'b0; i_clear = 1'b0; i_valid = 1'b0; i_is_call = 1'b0;
        i_is_ret = 1'b0; i_pc = '0; i_compressed = 1'b0; i_target = '0; i_ss_top = '0;
        i_ss_full = 1'b0; i_ss_empty = 1'b1;
        step(); step();
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_fault", 64'(o_fault), 64'd0);
        chk("rst_viol", 64'(o_violation), 64'd0);
        chk("rst_fault_pc", 64'(o_fault_pc), 64'd0);
        chk("rst_spill", 64'(o_spill_cnt), 64'd0);
        chk("rst_push", 64'(o_ss_push), 64'd0);
        chk("rst_calls", 64'(o_calls), 64'd0);
        chk("rst_rets", 64'(o_rets), 64'd0);
        rstn = 1'b1;
        step();

        // Disabled: events are dropped without stack traffic.
        ev(1'b1, 1'b0, 64'h9000, 1'b0, '0);
        i_enable = 1'b1;
        step();

        // Matching call/return.
        expect_ev(K_PUSH, 64'h1004);
        ev(1'b1, 1'b0, 64'h1000, 1'b0, '0);
        i_ss_empty = 1'b0; i_ss_top = 64'h1004;
        expect_ev(K_POP, '0);
        ev(1'b0, 1'b1, 64'h1010, 1'b0, 64'h1004);
        step();
        chk("match_fault", 64'(o_fault), 64'd0);

        // Compressed call, mismatching return.
        expect_ev(K_PUSH, 64'h2002);
        ev(1'b1, 1'b0, 64'h2000, 1'b1, '0);
        i_ss_top = 64'h2002;
        expect_ev(K_POP, '0);
        expect_ev(K_VIOL, 64'h2100);
        ev(1'b0, 1'b1, 64'h2100, 1'b0, 64'h2004);
        chk("mm_fault", 64'(o_fault), 64'd1);
        chk("mm_ready", 64'(o_ready), 64'd1);
        chk("mm_fault_pc", 64'(o_fault_pc), 64'h2100);
        ev(1'b1, 1'b0, 64'hA000, 1'b0, '0);
        chk("fault_sticky", 64'(o_fault), 64'd1);

        // Clear together with an event: event dropped, back to RUN.
        i_clear = 1'b1;
        ev(1'b1, 1'b0, 64'h6000, 1'b0, '0);
        i_clear = 1'b0;
        chk("clear_fault", 64'(o_fault), 64'd0);

        // Underflow.
        i_ss_empty = 1'b1;
        expect_ev(K_VIOL, 64'h7000);
        ev(1'b0, 1'b1, 64'h7000, 1'b0, 64'h1234);
        chk("uf_fault", 64'(o_fault), 64'd1);
        i_clear = 1'b1; step(); i_clear = 1'b0;
        expect_ev(K_PUSH, 64'h4004);
        ev(1'b1, 1'b0, 64'h4000, 1'b0, '0);

        // Spill while full, then drain through returns.
        i_ss_full = 1'b1;
        for (int i = 0; i < 3; i++) ev(1'b1, 1'b0, 64'h5000, 1'b0, '0);
        chk("spill3", 64'(o_spill_cnt), 64'd3);
        for (int i = 0; i < 3; i++) ev(1'b0, 1'b1, 64'h5100, 1'b0, 64'h1);
        chk("spill0", 64'(o_spill_cnt), 64'd0);
        chk("spill_fault", 64'(o_fault), 64'd0);

        // Spill counter saturation.
        for (int i = 0; i < 255; i++) ev(1'b1, 1'b0, 64'h5000, 1'b0, '0);
        chk("spill_max", 64'(o_spill_cnt), 64'd255);
        expect_ev(K_VIOL, 64'h5200);
        ev(1'b1, 1'b0, 64'h5200, 1'b0, '0);
        chk("spill_ovf_fault", 64'(o_fault), 64'd1);
        chk("spill_held", 64'(o_spill_cnt), 64'd255);
        i_clear = 1'b1; step(); i_clear = 1'b0;
        for (int i = 0; i < 255; i++) ev(1'b0, 1'b1, 64'h5300, 1'b0, '0);
        chk("spill_drain", 64'(o_spill_cnt), 64'd0);
        i_ss_full = 1'b0;

        // Coroutine swap: pop now, push next cycle with ready low.
        i_ss_empty = 1'b0; i_ss_top = 64'h5000;
        expect_ev(K_POP, '0);
        expect_ev(K_PUSH, 64'h3004);
        ev(1'b1, 1'b1, 64'h3000, 1'b0, 64'h5000);
        chk("coro_ready_low", 64'(o_ready), 64'd0);
        step();
        chk("coro_ready_high", 64'(o_ready), 64'd1);
        chk("coro_fault", 64'(o_fault), 64'd0);

        // Reset in PUSH_PEND drops the pending push.
        expect_ev(K_POP, '0);
        ev(1'b1, 1'b1, 64'h8000, 1'b0, 64'h5000);
        chk("pp_ready_low", 64'(o_ready), 64'd0);
        rstn = 1'b0;
        #1;
        chk("pp_rst_push", 64'(o_ss_push), 64'd0);
        chk("pp_rst_pop", 64'(o_ss_pop), 64'd0);
        chk("pp_rst_ready", 64'(o_ready), 64'd1);
        chk("pp_rst_fault_pc", 64'(o_fault_pc), 64'd0);
        chk("pp_rst_viol", 64'(o_violation), 64'd0);
        step(); step();
        rstn = 1'b1;
        step();

        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
